// File: rtl/ecal_coeff_lut_db_pkg.sv
// ecal_pkg: shared swap-FSM states, pipeline latencies and CPU address lane helper
package ecal_pkg;
  typedef enum logic {IDLE, PENDING} swap_state_e;
  localparam int LUT_LAT = 3;
  localparam int CPU_RD_LAT = 2;
  function automatic int unsigned lane_of(input logic [31:0] addr, input int unsigned lw);
    return addr & ((32'd1 << lw) - 32'd1);
  endfunction
endpackage

// File: rtl/ecal_coeff_lut_db_if.sv
// ecal_coeff_lut_db_if: lookup stream, CPU register port and bank-swap control bundle
interface ecal_coeff_lut_db_if #(
  parameter int CW = 10,
  parameter int LW = 1,
  parameter int NUM_COEFF = 2,
  parameter int COEFF_W = 32,
  parameter int TAG_W = 32
);
  logic in_valid;
  logic [CW-1:0] in_chan;
  logic [TAG_W-1:0] in_tag;
  logic out_valid;
  logic [CW-1:0] out_chan;
  logic [TAG_W-1:0] out_tag;
  logic [NUM_COEFF*COEFF_W-1:0] out_coeff;
  logic out_oor;
  logic cpu_we;
  logic cpu_re;
  logic [CW+LW-1:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic cpu_rvalid;
  logic frame_sync;
  logic swap_req;
  logic swap_ack;
  logic active_bank;
  logic swap_pending;
  logic wr_err;
  modport master (
    output in_valid, in_chan, in_tag, cpu_we, cpu_re, cpu_addr, cpu_wdata, frame_sync, swap_req,
    input out_valid, out_chan, out_tag, out_coeff, out_oor, cpu_rdata, cpu_rvalid, swap_ack,
    active_bank, swap_pending, wr_err
  );
  modport slave (
    input in_valid, in_chan, in_tag, cpu_we, cpu_re, cpu_addr, cpu_wdata, frame_sync, swap_req,
    output out_valid, out_chan, out_tag, out_coeff, out_oor, cpu_rdata, cpu_rvalid, swap_ack,
    active_bank, swap_pending, wr_err
  );
endinterface

// File: rtl/ecal_coeff_lut_db_bank.sv
// ecal_coeff_bank: simple dual-port RAM, registered outputs, port B read-first
module ecal_coeff_bank #(
  parameter int N_CHAN = 1024,
  parameter int CW = 10,
  parameter int COEFF_W = 32
) (
  input  logic clk,
  input  logic [CW-1:0] a_addr,
  output logic [COEFF_W-1:0] a_dout,
  input  logic b_we,
  input  logic [CW-1:0] b_addr,
  input  logic [COEFF_W-1:0] b_din,
  output logic [COEFF_W-1:0] b_dout
);
  logic [COEFF_W-1:0] mem [N_CHAN];
  always_ff @(posedge clk) a_dout <= mem[a_addr];
  always_ff @(posedge clk) begin
    if (b_we) mem[b_addr] <= b_din;
    b_dout <= mem[b_addr];
  end
endmodule

// File: rtl/ecal_coeff_lut_db.sv
// ecal_coeff_lut_db: double-buffered per-lane coefficient LUT with frame-synchronous bank swap
module ecal_coeff_lut_db
  import ecal_pkg::*;
#(
  parameter int N_CHAN = 1024,
  parameter int CW = $clog2(N_CHAN),
  parameter int NUM_COEFF = 2,
  parameter int COEFF_W = 32,
  parameter int TAG_W = 32,
  parameter int LW = NUM_COEFF > 1 ? $clog2(NUM_COEFF) : 1
) (
  input logic clk,
  input logic rst,
  ecal_coeff_lut_db_if.slave bus
);
  swap_state_e state;
  logic active_bank, s0_v, s0_oor, s0_bank, s1_v, s1_oor, s1_bank, r_v, r_bad, r_bank;
  logic [CW-1:0] s0_chan, s1_chan, c_chan;
  logic [TAG_W-1:0] s0_tag, s1_tag;
  logic [LW-1:0] r_lane;
  logic [COEFF_W-1:0] a_dout [2][NUM_COEFF];
  logic [COEFF_W-1:0] b_dout [2][NUM_COEFF];
  logic [NUM_COEFF*COEFF_W-1:0] lane_mux;
  logic c_bad, wr_ok, wr_drop, accept;
  int unsigned c_lane;
  assign c_chan = bus.cpu_addr[CW+LW-1:LW];
  assign c_lane = lane_of(32'(bus.cpu_addr), LW);
  assign c_bad = c_lane >= NUM_COEFF || 32'(c_chan) >= N_CHAN;
  // the shadow bank is frozen once a swap is pending since it is about to go live
  assign wr_ok = bus.cpu_we && !c_bad && state == IDLE;
  assign wr_drop = bus.cpu_we && !wr_ok;
  assign accept = bus.swap_req && state == IDLE;
  assign bus.active_bank = active_bank;
  assign bus.swap_pending = state == PENDING;
  for (genvar i = 0; i < 2; i++) begin : g_bank
    for (genvar j = 0; j < NUM_COEFF; j++) begin : g_lane
      ecal_coeff_bank #(.N_CHAN(N_CHAN), .CW(CW), .COEFF_W(COEFF_W)) u_ram (
        .clk,
        .a_addr(s0_chan),
        .a_dout(a_dout[i][j]),
        .b_we(wr_ok && active_bank != 1'(i) && c_lane == j),
        .b_addr(c_chan),
        .b_din(bus.cpu_wdata[COEFF_W-1:0]),
        .b_dout(b_dout[i][j])
      );
    end
  end
  for (genvar k = 0; k < NUM_COEFF; k++) begin : g_mux
    assign lane_mux[k*COEFF_W +: COEFF_W] = a_dout[s1_bank][k];
  end
  // bank is latched with the channel so a swap never tears an in-flight lookup
  always_ff @(posedge clk) begin
    if (rst) begin
      {s0_v, s0_oor, s0_bank, s0_chan, s0_tag} <= '0;
      {s1_v, s1_oor, s1_bank, s1_chan, s1_tag} <= '0;
      bus.out_valid <= 1'b0;
      bus.out_oor <= 1'b0;
      bus.out_chan <= '0;
      bus.out_tag <= '0;
      bus.out_coeff <= '0;
    end else begin
      {s0_v, s0_chan, s0_tag} <= {bus.in_valid, bus.in_chan, bus.in_tag};
      s0_oor <= 32'(bus.in_chan) >= N_CHAN;
      s0_bank <= active_bank;
      {s1_v, s1_oor, s1_bank, s1_chan, s1_tag} <= {s0_v, s0_oor, s0_bank, s0_chan, s0_tag};
      bus.out_valid <= s1_v;
      bus.out_oor <= s1_oor;
      bus.out_chan <= s1_chan;
      bus.out_tag <= s1_tag;
      bus.out_coeff <= s1_v && !s1_oor ? lane_mux : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_v, r_bad, r_bank, r_lane} <= '0;
      bus.cpu_rvalid <= 1'b0;
      bus.cpu_rdata <= '0;
    end else begin
      {r_v, r_bad, r_bank} <= {bus.cpu_re, c_bad, !active_bank};
      r_lane <= LW'(c_lane);
      bus.cpu_rvalid <= r_v;
      bus.cpu_rdata <= r_v && !r_bad ? 32'(b_dout[r_bank][r_lane]) : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      active_bank <= 1'b0;
      bus.swap_ack <= 1'b0;
      bus.wr_err <= 1'b0;
    end else begin
      bus.swap_ack <= state == PENDING && bus.frame_sync;
      if (accept) state <= PENDING;
      else if (state == PENDING && bus.frame_sync) begin
        state <= IDLE;
        active_bank <= !active_bank;
      end
      bus.wr_err <= (bus.wr_err && !accept) || wr_drop;
    end
  end
endmodule

// File: tb/tb_ecal_coeff_lut_db.sv
// tb_ecal_coeff_lut_db: randomized scoreboard bench against a bank/array reference model
module tb_ecal_coeff_lut_db;
  import ecal_pkg::*;
  localparam int NC = 1000;
  localparam int NL = 3;
  localparam int W = 24;
  typedef struct {
    logic [9:0] ch;
    logic [15:0] tag;
    logic [NL*W-1:0] coeff;
    logic oor;
    int due;
  } lk_t;
  typedef struct {
    logic [31:0] d;
    int due;
  } rd_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  lk_t lk_q[$];
  rd_t rd_q[$];
  bit [W-1:0] m [2][NC][NL];
  bit act, pend, werr;
  ecal_coeff_lut_db_if #(.CW(10), .LW(2), .NUM_COEFF(NL), .COEFF_W(W), .TAG_W(16)) bus ();
  ecal_coeff_lut_db #(.N_CHAN(NC), .NUM_COEFF(NL), .COEFF_W(W), .TAG_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask
  task automatic monitor();
    lk_t e;
    rd_t r;
    forever begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (lk_q.size() == 0) chk("lk_spurious", bus.out_valid, 0);
        else begin
          e = lk_q.pop_front();
          chk("lk_due", cyc, e.due);
          chk("lk_chan", bus.out_chan, e.ch);
          chk("lk_tag", bus.out_tag, e.tag);
          chk("lk_coeff", bus.out_coeff, e.coeff);
          chk("lk_oor", bus.out_oor, e.oor);
        end
      end else if (lk_q.size() != 0 && lk_q[0].due <= cyc) begin
        chk("lk_valid", bus.out_valid, 1);
        void'(lk_q.pop_front());
      end
      if (bus.cpu_rvalid) begin
        if (rd_q.size() == 0) chk("rd_spurious", bus.cpu_rvalid, 0);
        else begin
          r = rd_q.pop_front();
          chk("rd_due", cyc, r.due);
          chk("rd_data", bus.cpu_rdata, r.d);
        end
      end else if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
        chk("rd_valid", bus.cpu_rvalid, 1);
        void'(rd_q.pop_front());
      end
    end
  endtask
  task automatic drive(input bit v, input int ch, input bit [15:0] tag, input bit we, input bit re,
                       input int ach, input int al, input bit [31:0] wd, input bit sreq, input bit fs);
    lk_t e;
    rd_t r;
    bit bad, drop, ack;
    bus.in_valid = v;
    bus.in_chan = 10'(ch);
    bus.in_tag = tag;
    bus.cpu_we = we;
    bus.cpu_re = re;
    bus.cpu_addr = {10'(ach), 2'(al)};
    bus.cpu_wdata = wd;
    bus.swap_req = sreq;
    bus.frame_sync = fs;
    if (v) begin
      e.ch = 10'(ch);
      e.tag = tag;
      e.oor = ch >= NC;
      e.coeff = '0;
      if (!e.oor) for (int k = 0; k < NL; k++) e.coeff[k*W +: W] = m[act][ch][k];
      e.due = cyc + LUT_LAT;
      lk_q.push_back(e);
    end
    bad = ach >= NC || al >= NL;
    if (re) begin
      r.d = '0;
      if (!bad) r.d = 32'(m[!act][ach][al]);
      r.due = cyc + CPU_RD_LAT;
      rd_q.push_back(r);
    end
    drop = we && (bad || pend);
    if (we && !drop) m[!act][ach][al] = wd[W-1:0];
    if (sreq && !pend) werr = 0;
    if (drop) werr = 1;
    ack = 0;
    if (!pend && sreq) pend = 1;
    else if (pend && fs) begin
      act = !act;
      pend = 0;
      ack = 1;
    end
    @(posedge clk);
    #1;
    chk("swap_ack", bus.swap_ack, ack);
    chk("active_bank", bus.active_bank, act);
    chk("swap_pending", bus.swap_pending, pend);
    chk("wr_err", bus.wr_err, werr);
  endtask
  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    bus.in_valid = 0;
    bus.cpu_we = 0;
    bus.cpu_re = 0;
    bus.swap_req = 0;
    bus.frame_sync = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    lk_q.delete();
    rd_q.delete();
    {act, pend, werr} = '0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_rvalid", bus.cpu_rvalid, 0);
    chk("rst_active", bus.active_bank, 0);
    chk("rst_pending", bus.swap_pending, 0);
    chk("rst_ack", bus.swap_ack, 0);
    chk("rst_wr_err", bus.wr_err, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    {act, pend, werr} = '0;
    {bus.in_valid, bus.in_chan, bus.in_tag, bus.cpu_we, bus.cpu_re} = '0;
    {bus.cpu_addr, bus.cpu_wdata, bus.swap_req, bus.frame_sync} = '0;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_chan", bus.out_chan, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_out_coeff", bus.out_coeff, 0);
    chk("rst_out_oor", bus.out_oor, 0);
    chk("rst_rdata", bus.cpu_rdata, 0);
    chk("rst_rvalid", bus.cpu_rvalid, 0);
    chk("rst_ack", bus.swap_ack, 0);
    chk("rst_pending", bus.swap_pending, 0);
    chk("rst_wr_err", bus.wr_err, 0);
    chk("rst_active", bus.active_bank, 0);
    rst = 0;
    for (int c = 0; c < NC; c++)
      for (int l = 0; l < NL; l++)
        drive(0, 0, 0, 1, 0, c, l, 32'h11110000 * (l + 1) + c, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int c = 0; c < NC; c++)
      for (int l = 0; l < NL; l++) drive(0, 0, 0, 1, 0, c, l, $urandom, 0, 0);
    drive(0, 0, 0, 1, 0, 1003, 0, 32'h12345678, 0, 0);
    drive(0, 0, 0, 1, 0, 5, 3, 32'h12345678, 0, 0);
    drive(0, 0, 0, 1, 0, 999, 2, 32'hCAFEBABE, 0, 0);
    drive(0, 0, 0, 0, 1, 999, 2, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1000, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 5, 3, 0, 0, 0);
    for (int c = 0; c < 1024; c++) drive(1, c, 16'($urandom), 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++)
      drive(1, (i * 37) % 1024, 16'(i), i == 10, 0, 10, 1, 32'hDEAD0000, i == 3 || i == 5 || i == 8 || i == 25,
            i == 2 || i == 20 || i == 25 || i == 32);
    drive(1, 10, 16'hAAAA, 0, 1, 10, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 7, 0, 32'hABCDEF12, 0, 0);
    drive(0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1023), 16'($urandom), $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 1009), $urandom_range(0, 3), $urandom,
            $urandom_range(0, 40) == 0, $urandom_range(0, 20) == 0);
    idle(4);
    drive(1, 11, 16'h0011, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 12, 16'h0012, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 13, 16'h0013, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(8);
    drive(1, 21, 16'h0021, 0, 1, 21, 0, 0, 0, 0);
    idle(8);
    chk("lk_drain", lk_q.size(), 0);
    chk("rd_drain", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ecal_coeff_lut_db.md
# ecal_coeff_lut_db

Double-buffered, parametrised energy-calibration coefficient store for the per-resonator wavelength capture path. It replaces the single-bank coefficient RAM with two banks: software loads the shadow bank through a 32-bit register port while the pixel pipeline reads the active bank. Banks swap atomically on a frame boundary. Lookups are pipelined at one per cycle with a channel/tag pass-through, and coefficients are presented per lane for the downstream polynomial evaluator.

## Interface
- N_CHAN, 1024: resonator channels per bank; need not be a power of 2.
- CW, $clog2(N_CHAN): channel index width.
- NUM_COEFF, 2: coefficient lanes per channel.
- COEFF_W, 32: coefficient width, 1..32.
- TAG_W, 32: sideband carried alongside each lookup (phase sample, timestamp).
- LW, max(1,$clog2(NUM_COEFF)): lane index width.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  lookup request.
- in_chan  in  CW  channel to look up.
- in_tag  in  TAG_W  sideband.
- out_valid  out  1  lookup result valid.
- out_chan  out  CW  echoed channel.
- out_tag  out  TAG_W  echoed sideband.
- out_coeff  out  NUM_COEFF*COEFF_W  lane k occupies bits [k*COEFF_W +: COEFF_W].
- out_oor  out  1  in_chan was >= N_CHAN.
- cpu_we  in  1  write strobe to the shadow bank.
- cpu_re  in  1  read strobe from the shadow bank.
- cpu_addr  in  CW+LW  {chan, lane}.
- cpu_wdata  in  32  write data; low COEFF_W bits stored.
- cpu_rdata  out  32  read data, zero-extended.
- cpu_rvalid  out  1  read data valid.
- frame_sync  in  1  start-of-frame pulse.
- swap_req  in  1  request a bank swap.
- swap_ack  out  1  one-cycle pulse when the swap executes.
- active_bank  out  1  bank currently serving lookups.
- swap_pending  out  1  swap requested but not yet executed.
- wr_err  out  1  sticky flag: a write was dropped.

## Operation
- Two banks, each N_CHAN x NUM_COEFF lanes. The shadow bank is always ~active_bank.
- Lookups are unconditional; there is no backpressure. The bank index is captured together with in_chan at stage 0, so a lookup already in flight is never torn by a swap.
- in_chan >= N_CHAN: out_coeff=0, out_oor=1, out_valid=1.
- CPU write with lane >= NUM_COEFF or chan >= N_CHAN: the write is dropped and wr_err is set.
- CPU read with lane >= NUM_COEFF or chan >= N_CHAN: returns 0, with cpu_rvalid still asserted.
- CPU read and write to the same address in the same cycle: the read returns the old data (read-first).
- Swap FSM, IDLE to PENDING:
  - swap_req in IDLE moves to PENDING.
  - On the edge where frame_sync=1 in PENDING, active_bank toggles, swap_ack pulses and the FSM returns to IDLE.
  - swap_req while already PENDING is merged; no second swap occurs.
  - swap_req and frame_sync together in IDLE: no swap that cycle; the swap executes at the next frame_sync.
- A CPU write issued while PENDING is dropped and wr_err is set, because that bank is about to go live.
- wr_err clears on rst or on a new swap_req accepted in IDLE.
- Reset: out_valid=0, out_chan=0, out_tag=0, out_coeff=0, out_oor=0, cpu_rdata=0, cpu_rvalid=0, swap_ack=0, swap_pending=0, wr_err=0, active_bank=0, FSM=IDLE. RAM contents are not cleared.
- rst asserted mid-operation flushes the lookup pipeline (all valids to 0) and discards any pending swap.

## Timing
- Lookup latency is 3 cycles: in_valid at edge N gives out_valid at edge N+3.
- The lookup path is three stages: input register, RAM read (registered primitive output), output register.
- Throughput is 1 lookup per cycle.
- The echoed out_chan, out_tag and out_oor are delay-matched to out_coeff.
- CPU read latency is 2 cycles: cpu_re at N gives cpu_rvalid at N+2.
- A CPU write is visible to a CPU read issued at the next cycle or later.
- Bank-swap edge:
  - A lookup accepted on the same edge as the executing frame_sync uses the old bank.
  - A lookup accepted one cycle later uses the new bank.
- swap_ack and the active_bank change appear on the same edge.

## Structure
- Package ecal_pkg holds:
  - the swap FSM state enum (IDLE, PENDING);
  - the lookup pipeline depth constant LUT_LAT=3;
  - the CPU read latency constant CPU_RD_LAT=2;
  - the lane-slicing helper function.
- Sub-module ecal_coeff_bank is a simple dual-port RAM, COEFF_W wide and N_CHAN deep, with a registered output.
  - It is instantiated 2 x NUM_COEFF times (one per bank per lane).
  - Port A serves lookup reads; port B serves CPU writes and reads.

## Test plan
- Default parameters: CPU writes lane0=0x11110000+ch and lane1=0x22220000+ch for ch 0..1023, then swap_req and frame_sync. A streaming lookup of ch 0..1023 returns matching coefficients with out_valid exactly 3 cycles after in_valid and no gaps.
- Lookups stream continuously across a swap. The lookup on the frame_sync edge returns old-bank data; the next cycle returns new-bank data. swap_ack is a 1-cycle pulse.
- swap_req is asserted three times before frame_sync. Exactly one toggle occurs. A cpu_we issued during PENDING leaves the RAM unchanged and sets wr_err=1.
- N_CHAN=1000: a lookup of ch 1000 gives out_coeff=0 and out_oor=1. A CPU write to ch 1003 is dropped with wr_err=1. A write to lane 2 with NUM_COEFF=3 is accepted.
- Same-cycle cpu_we and cpu_re at the same address: cpu_rdata returns the old value at N+2; a read at N+1 returns the new value.
- rst asserted with 3 lookups in flight and a swap pending: out_valid=0 from the next cycle, active_bank=0, swap_pending=0, and no swap_ack.
